// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  // Loader FSM states, in the order a normal load walks through them.
  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  // Header is a big-endian word count; payload words are big-endian too.
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Byte address of word number idx, counted from base.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Shifts incoming bytes into a 32-bit big-endian word and tracks which
// byte of the word comes next. The first byte ends up in bits [31:24].
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [31:0]      word_q;
  logic [IDX_W-1:0] idx_q;

  // Shift register and byte index; clear drops any partial word.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (shift_i) begin
      word_q <= {word_q[23:0], byte_i};
      idx_q  <= idx_q + 1'b1;
    end
  end

  assign word_o = word_q;
  // High while waiting for the final byte of the current word.
  assign last_o = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a byte stream (2-byte word count, then big-endian
// words), writes the words into instruction memory and keeps the core in
// reset until the whole image is in place.
//
// Handshake: a byte moves from upstream when in_valid && in_ready are both
// high on a rising edge of CLK. in_ready depends only on the current state,
// never on in_valid, so upstream may hold a byte for as long as it likes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,  // must be word-aligned
  parameter int          TIMEOUT   = 1_000_000       // 0 disables the idle timeout
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        load_req,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded,
  output state_e      dbg_state_o
);

  localparam int          HDR_W   = HDR_BYTES * 8;
  localparam int          TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_e             state_q;
  logic [HDR_W-1:0]   n_q;
  logic [TW-1:0]      tmo_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               cpu_reset_q;
  logic               done_q;
  logic               err_q;
  logic [15:0]        words_q;

  logic               xfer;
  logic               tmo_hit;
  logic [HDR_W-1:0]   hdr_n;
  logic [15:0]        words_inc;
  logic               asm_shift;
  logic               asm_clr;
  logic [31:0]        asm_word;
  logic               asm_last;

  assign in_ready  = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                     (state_q == ST_DATA);
  assign xfer      = in_valid && in_ready;
  // Full header value as it will be once the low byte lands this cycle.
  assign hdr_n     = {n_q[HDR_W-1:8], in_data};
  assign words_inc = words_q + 16'd1;
  // Idle limit reached: this would be the TIMEOUT-th consecutive idle edge.
  assign tmo_hit   = (TIMEOUT != 0) && !xfer && (tmo_q == TW'(TIMEOUT - 1));

  // Only payload bytes go into the assembler; outside DATA it is held clear,
  // which discards a partial word on timeout and restarts the byte index on
  // every new load. WRITE can clear it too since the next word shifts in
  // four fresh bytes.
  assign asm_shift = xfer && (state_q == ST_DATA);
  assign asm_clr   = (state_q != ST_DATA);

  word_assembler u_asm (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .clr_i   (asm_clr),
    .shift_i (asm_shift),
    .byte_i  (in_data),
    .word_o  (asm_word),
    .last_o  (asm_last)
  );

  // Loader FSM with registered outputs and the mid-load idle counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_HDR0;
      n_q         <= '0;
      tmo_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_HDR0: begin
          tmo_q <= '0;
          if (xfer) begin
            n_q[HDR_W-1:8] <= in_data;
            state_q        <= ST_HDR1;
          end
        end

        ST_HDR1: begin
          if (xfer) begin
            n_q   <= hdr_n;
            tmo_q <= '0;
            if (hdr_n == '0) begin
              // Empty image: release the core straight away.
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else if (32'(hdr_n) > DEPTH_U) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_DATA;
            end
          end else if (tmo_hit) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (xfer) begin
            tmo_q <= '0;
            if (asm_last) begin
              // The final byte is still on in_data this cycle.
              state_q <= ST_WRITE;
              we_q    <= 1'b1;
              wdata_q <= {asm_word[23:0], in_data};
            end
          end else if (tmo_hit) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        ST_WRITE: begin
          // addr_q already points at this word; advance it for the next one.
          tmo_q   <= '0;
          words_q <= words_inc;
          addr_q  <= word_addr(BASE_ADDR, words_inc);
          if (words_inc == n_q) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
          end else begin
            state_q <= ST_DATA;
          end
        end

        ST_DONE: begin
          tmo_q <= '0;
          if (load_req) begin
            state_q     <= ST_HDR0;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
            words_q     <= '0;
            addr_q      <= BASE_ADDR;
            n_q         <= '0;
          end
        end

        ST_ERR: begin
          // The core stays in reset for as long as the error is flagged.
          tmo_q       <= '0;
          cpu_reset_q <= 1'b1;
          if (load_req) begin
            state_q <= ST_HDR0;
            err_q   <= 1'b0;
            words_q <= '0;
            addr_q  <= BASE_ADDR;
            n_q     <= '0;
          end
        end

        default: begin
          state_q     <= ST_ERR;
          err_q       <= 1'b1;
          cpu_reset_q <= 1'b1;
          tmo_q       <= '0;
        end
      endcase
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader with a write scoreboard.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          TMO   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        load_req;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;
  state_e      dbg_state;

  int compared = 0;
  int fails    = 0;

  logic [63:0] exp_q[$];   // {addr, data} of each expected memory write
  logic [7:0]  stim_q[$];  // byte stream for the current load
  logic [63:0] mon_e;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .CLK          (clk),
    .RESET        (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .load_req     (load_req),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .dbg_state_o  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit (compared=%0d)", compared);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected writes for the stream in stim_q. Only
  // complete words of a legal, non-empty header produce writes.
  task automatic model_from_stim();
    int n;
    n = int'({stim_q[0], stim_q[1]});
    if (n == 0 || n > DEPTH) return;
    for (int w = 0; w < n; w++) begin
      if (2 + 4 * w + 3 < stim_q.size())
        exp_q.push_back({BASE + 32'(4 * w),
                         stim_q[2 + 4 * w], stim_q[3 + 4 * w],
                         stim_q[4 + 4 * w], stim_q[5 + 4 * w]});
    end
  endtask

  // Offer one byte after 0..gap_max idle cycles; returns just after the
  // edge on which it transferred.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    int budget;
    gap = $urandom_range(gap_max, 0);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    budget   = 0;
    while (in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (in_ready !== 1'b1) chk("send_stall", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    @(negedge clk);
    in_valid = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Send stim_q; pulse load_req after byte indices lr_a and lr_b.
  task automatic send_stim(input int gap_max, input int lr_a, input int lr_b);
    for (int i = 0; i < stim_q.size(); i++) begin
      send_byte(stim_q[i], gap_max);
      if (i == lr_a || i == lr_b) begin
        pulse_load_req();
        chk("lr_ignored_done", {63'd0, done}, 64'd0);
        chk("lr_ignored_cpurst", {63'd0, cpu_reset}, 64'd1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},     {63'd0, imem_we}, 64'd0);
    chk({tag, "_addr"},   {32'd0, imem_addr}, {32'd0, BASE});
    chk({tag, "_wdata"},  {32'd0, imem_wdata}, 64'd0);
    chk({tag, "_cpurst"}, {63'd0, cpu_reset}, 64'd1);
    chk({tag, "_done"},   {63'd0, done}, 64'd0);
    chk({tag, "_err"},    {63'd0, err}, 64'd0);
    chk({tag, "_words"},  {48'd0, words_loaded}, 64'd0);
    chk({tag, "_ready"},  {63'd0, in_ready}, 64'd1);
    chk({tag, "_state"},  {61'd0, dbg_state}, {61'd0, ST_HDR0});
  endtask

  // Scoreboard: every write strobe is matched against the model.
  always @(negedge clk) begin
    if (rst === 1'b0 && imem_we === 1'b1) begin
      chk("we_in_ready", {63'd0, in_ready}, 64'd0);
      chk("we_cpu_reset", {63'd0, cpu_reset}, 64'd1);
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {63'd0, imem_we}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {32'd0, imem_addr}, {32'd0, mon_e[63:32]});
        chk("wr_data", {32'd0, imem_wdata}, {32'd0, mon_e[31:0]});
      end
    end
  end

  initial begin
    int k;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Two words, back to back.
    stim_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    model_from_stim();
    send_stim(0, -1, -1);
    @(posedge clk);
    @(negedge clk);
    chk("t1_done", {63'd0, done}, 64'd1);
    chk("t1_cpurst", {63'd0, cpu_reset}, 64'd0);
    chk("t1_words", {48'd0, words_loaded}, 64'd2);
    chk("t1_ready", {63'd0, in_ready}, 64'd0);
    chk("t1_pending", 64'(exp_q.size()), 64'd0);
    pulse_load_req();
    chk("t1_lr_done", {63'd0, done}, 64'd0);
    chk("t1_lr_cpurst", {63'd0, cpu_reset}, 64'd1);
    chk("t1_lr_words", {48'd0, words_loaded}, 64'd0);
    chk("t1_lr_ready", {63'd0, in_ready}, 64'd1);

    // Empty image.
    stim_q = '{8'h00, 8'h00};
    model_from_stim();
    send_stim(0, -1, -1);
    @(negedge clk);
    chk("t2_done", {63'd0, done}, 64'd1);
    chk("t2_cpurst", {63'd0, cpu_reset}, 64'd0);
    chk("t2_words", {48'd0, words_loaded}, 64'd0);
    pulse_load_req();

    // Oversized header.
    stim_q = '{8'h01, 8'h01};
    model_from_stim();
    send_stim(0, -1, -1);
    @(negedge clk);
    chk("t3_err", {63'd0, err}, 64'd1);
    chk("t3_cpurst", {63'd0, cpu_reset}, 64'd1);
    chk("t3_ready", {63'd0, in_ready}, 64'd0);
    chk("t3_done", {63'd0, done}, 64'd0);
    pulse_load_req();
    chk("t3_lr_err", {63'd0, err}, 64'd0);
    chk("t3_lr_ready", {63'd0, in_ready}, 64'd1);

    // Idle timeout mid-word.
    stim_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    model_from_stim();
    send_stim(0, -1, -1);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    chk("t4_err_early", {63'd0, err}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t4_err", {63'd0, err}, 64'd1);
    chk("t4_ready", {63'd0, in_ready}, 64'd0);
    chk("t4_cpurst", {63'd0, cpu_reset}, 64'd1);
    pulse_load_req();
    chk("t4_lr_err", {63'd0, err}, 64'd0);

    // Reset in the middle of a word, then a fresh load.
    stim_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    model_from_stim();
    send_stim(0, -1, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("t5_rst");
    stim_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    model_from_stim();
    send_stim(0, -1, -1);
    @(posedge clk);
    @(negedge clk);
    chk("t5_done", {63'd0, done}, 64'd1);
    chk("t5_words", {48'd0, words_loaded}, 64'd1);
    chk("t5_pending", 64'(exp_q.size()), 64'd0);
    pulse_load_req();

    // Random payload, random valid gaps, load_req during DATA and WRITE.
    stim_q = '{8'h00, 8'h03};
    for (int i = 0; i < 12; i++) stim_q.push_back(8'($urandom));
    model_from_stim();
    send_stim(3, 4, 5);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t6_done", {63'd0, done}, 64'd1);
    chk("t6_cpurst", {63'd0, cpu_reset}, 64'd0);
    chk("t6_words", {48'd0, words_loaded}, 64'd3);
    chk("t6_pending", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

endmodule
